// File: rtl/medidor_de_frecuencia_pkg.sv
// Shared definitions for the frequency meter: FSM state encodings and the
// default widths, so the divider and the meter agree on the frecnum encoding.
package medidor_de_frecuencia_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LATCH   = 2'd2
  } estado_t;

  localparam int GATE_CYCLES_DEF = 100000;
  localparam int CNT_W_DEF       = 8;
  localparam int SYNC_STAGES_DEF = 2;

  // Gate counter width; a one-cycle window still needs a 1-bit counter.
  function automatic int gate_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/sincronizador_flanco.sv
// Brings an asynchronous input into the clk domain and produces a registered
// one-cycle pulse on each rising edge. Total latency from d_async to
// edge_rise is SYNC_STAGES+1 cycles.
module sincronizador_flanco
  import medidor_de_frecuencia_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic d_async,
  output logic edge_rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d;

  if (SYNC_STAGES < 2) begin : g_bad_stages
    $error("sincronizador_flanco: SYNC_STAGES must be at least 2");
  end

  // Synchronizer chain, delayed copy and rising-edge register.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q    <= '0;
      s_d       <= 1'b0;
      edge_rise <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], d_async};
      s_d       <= sync_q[SYNC_STAGES-1];
      edge_rise <= sync_q[SYNC_STAGES-1] & ~s_d;
    end
  end

endmodule

// File: rtl/medidor_de_frecuencia.sv
// Frequency meter: counts rising edges of sig_in over a gate window of
// GATE_CYCLES clocks and reports the count on frecnum with a valid pulse.
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   ST_IDLE    | stopped, counters held at zero
//   ST_MEASURE | gate open, counting edges
//   ST_LATCH   | one cycle: copy count to outputs, edges here are dropped
module medidor_de_frecuencia
  import medidor_de_frecuencia_pkg::*;
#(
  parameter int GATE_CYCLES = GATE_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sig_in,
  output logic [CNT_W-1:0] frecnum,
  output logic             valid,
  output logic             overflow,
  output logic             busy
);

  localparam int                GATE_W    = gate_width(GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  estado_t           state;
  estado_t           state_next;
  logic [GATE_W-1:0] gate_cnt;
  logic [CNT_W-1:0]  edge_cnt;
  logic              ovf;
  logic              edge_rise;
  logic              gate_done;

  sincronizador_flanco #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .reset    (reset),
    .d_async  (sig_in),
    .edge_rise(edge_rise)
  );

  assign gate_done = (gate_cnt == GATE_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; dropping enable aborts a window but never a latch.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable) state_next = ST_MEASURE;
      end
      ST_MEASURE: begin
        busy = 1'b1;
        if (!enable)        state_next = ST_IDLE;
        else if (gate_done) state_next = ST_LATCH;
      end
      ST_LATCH: begin
        busy       = 1'b1;
        state_next = enable ? ST_MEASURE : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Gate and saturating edge counters; cleared whenever the gate is closed,
  // so a new window always starts from zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
      ovf      <= 1'b0;
    end else if (state == ST_MEASURE) begin
      gate_cnt <= gate_cnt + GATE_W'(1);
      if (edge_rise) begin
        if (edge_cnt == CNT_MAX) ovf <= 1'b1;
        else                     edge_cnt <= edge_cnt + CNT_W'(1);
      end
    end else begin
      gate_cnt <= '0;
      edge_cnt <= '0;
      ovf      <= 1'b0;
    end
  end

  // Result registers; valid is registered so it lines up with new frecnum.
  always_ff @(posedge clk) begin
    if (reset) begin
      frecnum  <= '0;
      overflow <= 1'b0;
      valid    <= 1'b0;
    end else begin
      valid <= (state == ST_LATCH);
      if (state == ST_LATCH) begin
        frecnum  <= edge_cnt;
        overflow <= ovf;
      end
    end
  end

endmodule
